// File: rtl/commit_reorder_unit_pkg.sv
// Shared definitions for the commit reorder unit: default geometry and the
// layout of one per-branch holding slot.
package commit_reorder_unit_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_N_BRANCHES = 4;
  localparam int DEF_N_CHANNELS = 16;
  localparam int DEF_ID_WIDTH   = 8;
  localparam int DEF_MAC_BRANCH = 0;
  localparam int DEF_CH_W       = $clog2(DEF_N_CHANNELS);

  typedef struct packed {
    logic [2*DEF_DATA_WIDTH-1:0] result;
    logic [DEF_CH_W-1:0]         dest;
    logic [DEF_ID_WIDTH-1:0]     id;
    logic                        overwrite;
    logic                        full;
  } commit_slot_t;

endpackage

// File: rtl/commit_reorder_unit_slot.sv
// One-entry holding slot for a single branch: accepts a result when empty and
// keeps it until the commit logic clears it.
module commit_slot #(
  parameter int RES_W    = 32,
  parameter int CH_W     = 4,
  parameter int ID_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  input  logic [RES_W-1:0]    result,
  input  logic [CH_W-1:0]     dest,
  input  logic [ID_WIDTH-1:0] commit_id,
  input  logic                acc_overwrite,
  input  logic                clear,
  output logic                in_ready,
  output logic                full,
  output logic [RES_W-1:0]    slot_result,
  output logic [CH_W-1:0]     slot_dest,
  output logic [ID_WIDTH-1:0] slot_id,
  output logic                slot_overwrite
);

  logic                r_full;
  logic [RES_W-1:0]    r_result;
  logic [CH_W-1:0]     r_dest;
  logic [ID_WIDTH-1:0] r_id;
  logic                r_overwrite;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full      <= 1'b0;
      r_result    <= '0;
      r_dest      <= '0;
      r_id        <= '0;
      r_overwrite <= 1'b0;
    end else if (clear) begin
      r_full <= 1'b0;
    end else if (in_valid && !r_full) begin
      r_full      <= 1'b1;
      r_result    <= result;
      r_dest      <= dest;
      r_id        <= commit_id;
      r_overwrite <= acc_overwrite;
    end
  end

  // Refill is only possible the cycle after a clear because ready is ~full.
  assign in_ready       = ~r_full;
  assign full           = r_full;
  assign slot_result    = r_result;
  assign slot_dest      = r_dest;
  assign slot_id        = r_id;
  assign slot_overwrite = r_overwrite;

endmodule

// File: rtl/commit_reorder_unit.sv
// Reorders results arriving out of order from several branches and commits
// them strictly in commit-ID order, one per cycle, to channel or accumulator.
module commit_reorder_unit
  import commit_reorder_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_BRANCHES = DEF_N_BRANCHES,
  parameter int N_CHANNELS = DEF_N_CHANNELS,
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int MAC_BRANCH = DEF_MAC_BRANCH,
  localparam int CH_W      = $clog2(N_CHANNELS)
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   enable,
  input  logic                                   sample_tick,
  input  logic signed [DATA_WIDTH-1:0]           sample_in,
  input  logic [N_BRANCHES-1:0]                  in_valid,
  output logic [N_BRANCHES-1:0]                  in_ready,
  input  logic [N_BRANCHES-1:0][2*DATA_WIDTH-1:0] result,
  input  logic [N_BRANCHES-1:0][CH_W-1:0]        dest,
  input  logic [N_BRANCHES-1:0][ID_WIDTH-1:0]    commit_id,
  input  logic [N_BRANCHES-1:0]                  acc_overwrite,
  output logic [CH_W-1:0]                        channel_write_addr,
  output logic [DATA_WIDTH-1:0]                  channel_write_val,
  output logic                                   channel_write_enable,
  output logic [2*DATA_WIDTH-1:0]                accumulator_write_val,
  output logic                                   accumulator_write_enable,
  output logic                                   accumulator_add_enable,
  output logic [ID_WIDTH-1:0]                    next_commit_id,
  output logic [15:0]                            commits_this_sample,
  output logic                                   id_collision
);

  localparam int RES_W = 2 * DATA_WIDTH;

  logic [N_BRANCHES-1:0] w_full;
  logic [N_BRANCHES-1:0] w_slot_ovw;
  logic [RES_W-1:0]      w_slot_result [N_BRANCHES];
  logic [CH_W-1:0]       w_slot_dest   [N_BRANCHES];
  logic [ID_WIDTH-1:0]   w_slot_id     [N_BRANCHES];
  logic [N_BRANCHES-1:0] w_match;
  logic [N_BRANCHES-1:0] w_grant;
  logic [N_BRANCHES-1:0] w_clear;
  logic [RES_W-1:0]      w_sel_result;
  logic [CH_W-1:0]       w_sel_dest;
  logic                  w_sel_ovw;
  logic                  w_tick;
  logic                  w_commit;

  logic [ID_WIDTH-1:0]   r_next_id;
  logic [15:0]           r_commits;
  logic                  r_collision;
  logic [CH_W-1:0]       r_ch_addr;
  logic [DATA_WIDTH-1:0] r_ch_val;
  logic                  r_ch_we;
  logic [RES_W-1:0]      r_acc_val;
  logic                  r_acc_we;
  logic                  r_acc_add;

  for (genvar g = 0; g < N_BRANCHES; g++) begin : g_slot
    commit_slot #(.RES_W(RES_W), .CH_W(CH_W), .ID_WIDTH(ID_WIDTH)) u_slot (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_valid      (in_valid[g]),
      .result        (result[g]),
      .dest          (dest[g]),
      .commit_id     (commit_id[g]),
      .acc_overwrite (acc_overwrite[g]),
      .clear         (w_clear[g]),
      .in_ready      (in_ready[g]),
      .full          (w_full[g]),
      .slot_result   (w_slot_result[g]),
      .slot_dest     (w_slot_dest[g]),
      .slot_id       (w_slot_id[g]),
      .slot_overwrite(w_slot_ovw[g])
    );
    assign w_match[g] = w_full[g] && (w_slot_id[g] == r_next_id);
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_grant      = '0;
    w_sel_result = '0;
    w_sel_dest   = '0;
    w_sel_ovw    = 1'b0;
    for (int i = 0; i < N_BRANCHES; i++) begin
      if (w_match[i] && (w_grant == '0)) w_grant[i] = 1'b1;
    end
    for (int i = 0; i < N_BRANCHES; i++) begin
      if (w_grant[i]) begin
        w_sel_result = w_sel_result | w_slot_result[i];
        w_sel_dest   = w_sel_dest | w_slot_dest[i];
        w_sel_ovw    = w_sel_ovw | w_slot_ovw[i];
      end
    end
  end

  // The sample strobe preempts commits; matching slots simply wait.
  assign w_tick   = enable && sample_tick;
  assign w_commit = enable && !sample_tick && (w_match != '0);
  assign w_clear  = w_commit ? w_grant : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_next_id   <= '0;
      r_commits   <= '0;
      r_collision <= 1'b0;
      r_ch_addr   <= '0;
      r_ch_val    <= '0;
      r_ch_we     <= 1'b0;
      r_acc_val   <= '0;
      r_acc_we    <= 1'b0;
      r_acc_add   <= 1'b0;
    end else begin
      r_ch_we   <= 1'b0;
      r_acc_we  <= 1'b0;
      r_acc_add <= 1'b0;
      if ((w_match & (w_match - N_BRANCHES'(1))) != '0) r_collision <= 1'b1;
      if (w_tick) begin
        r_ch_addr <= '0;
        r_ch_val  <= sample_in;
        r_ch_we   <= 1'b1;
        r_commits <= '0;
      end else if (w_commit) begin
        r_next_id <= r_next_id + ID_WIDTH'(1);
        if (r_commits != 16'hFFFF) r_commits <= r_commits + 16'd1;
        if (w_grant[MAC_BRANCH]) begin
          r_acc_val <= w_sel_result;
          r_acc_we  <= 1'b1;
          r_acc_add <= ~w_sel_ovw;
        end else begin
          r_ch_addr <= w_sel_dest;
          r_ch_val  <= w_sel_result[DATA_WIDTH-1:0];
          r_ch_we   <= 1'b1;
        end
      end
    end
  end

  assign channel_write_addr       = r_ch_addr;
  assign channel_write_val        = r_ch_val;
  assign channel_write_enable     = r_ch_we;
  assign accumulator_write_val    = r_acc_val;
  assign accumulator_write_enable = r_acc_we;
  assign accumulator_add_enable   = r_acc_add;
  assign next_commit_id           = r_next_id;
  assign commits_this_sample      = r_commits;
  assign id_collision             = r_collision;

endmodule

// File: doc/commit_reorder_unit.md
COMMIT_REORDER_UNIT -- requirements
Module: commit_reorder_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, channel data width.
REQ-002 SHALL have parameter N_BRANCHES, default 4, number of instruction branches.
REQ-003 SHALL have parameter N_CHANNELS, default 16, channel register count; address width CH_W = clog2(N_CHANNELS).
REQ-004 SHALL have parameter ID_WIDTH, default 8, commit ID width.
REQ-005 SHALL have parameter MAC_BRANCH, default 0, index of the branch that writes the accumulator.
REQ-006 SHALL have ports: clk input 1, clock.
REQ-007 SHALL have ports: reset_n input 1, asynchronous active-low reset.
REQ-008 SHALL have ports: enable input 1, core run enable.
REQ-009 SHALL have ports: sample_tick input 1, new-sample strobe; sample_in input DATA_WIDTH, signed sample.
REQ-010 SHALL have ports: in_valid/in_ready, N_BRANCHES each, input/output, per-branch handshake.
REQ-011 SHALL have ports: result input N_BRANCHES x 2*DATA_WIDTH; dest input N_BRANCHES x CH_W; commit_id input N_BRANCHES x ID_WIDTH; acc_overwrite input N_BRANCHES.
REQ-012 SHALL have ports: channel_write_addr output CH_W; channel_write_val output DATA_WIDTH; channel_write_enable output 1.
REQ-013 SHALL have ports: accumulator_write_val output 2*DATA_WIDTH; accumulator_write_enable, accumulator_add_enable output 1 each.
REQ-014 SHALL have ports: next_commit_id output ID_WIDTH; commits_this_sample output 16; id_collision output 1, sticky error.

Function
REQ-015 Each branch SHALL own a one-entry holding slot (result, dest, id, overwrite, full flag).
REQ-016 in_ready[i] SHALL equal ~full[i]; a transfer occurs when in_valid[i] && in_ready[i] at a clock edge, setting full[i] and capturing the fields.
REQ-017 A slot SHALL be accepted regardless of its commit_id; arrival order need not match ID order.
REQ-018 Each cycle, match[i] = full[i] && id[i] == next_commit_id; at most one branch SHALL commit per cycle, lowest index winning if several match.
REQ-019 If more than one match bit is set, id_collision SHALL be set and held until reset.
REQ-020 Commit of branch i SHALL, on the next edge, clear full[i], increment next_commit_id (wrap modulo 2^ID_WIDTH), increment commits_this_sample (saturating at 0xFFFF), and register the write outputs.
REQ-021 If i == MAC_BRANCH: accumulator_write_val = full 2*DATA_WIDTH result, accumulator_write_enable = 1, accumulator_add_enable = ~overwrite; otherwise channel_write_addr = dest, channel_write_val = result[DATA_WIDTH-1:0], channel_write_enable = 1.
REQ-022 Write strobes SHALL be single-cycle pulses; latency from slot capture to write strobe SHALL be at least 2 cycles (capture edge, commit edge).
REQ-023 sample_tick with enable SHALL take priority: next edge drives channel_write_addr = 0, channel_write_val = sample_in, channel_write_enable = 1, and resets commits_this_sample to 0.
REQ-024 During a sample_tick cycle no commit SHALL occur; matching slots remain held and commit on a later cycle; no result is dropped.
REQ-025 Slot capture SHALL continue during sample_tick cycles.
REQ-026 With enable low: no commits, no writes, sample_tick ignored; slots still accept until full.
REQ-027 Slot freed and newly filled at the same edge SHALL be impossible: in_ready is low while full, so refill occurs the cycle after commit.

Reset
REQ-028 On reset_n low, asynchronously: all full flags 0, next_commit_id 0, commits_this_sample 0, id_collision 0, all write enables 0, write addr/val and accumulator value 0.
REQ-029 Reset asserted mid-operation SHALL discard held slots without producing writes; first cycle after release expects commit_id 0.

Structure
REQ-030 Shared package SHALL hold the commit slot struct typedef and the default parameter constants.
REQ-031 One sub-module commit_slot SHALL implement a single branch holding slot, instantiated N_BRANCHES times.

Verification
REQ-032 In order: branch 1 id 0 dest 3 result 0x0000_1234, then branch 2 id 1 dest 5 result 0x5678 -> channel writes (3,0x1234) then (5,0x5678), next_commit_id 2.
REQ-033 Out of order: branch 2 id 1 arrives 3 cycles before branch 1 id 0 -> writes occur id 0 then id 1; branch 2 in_ready low until its commit.
REQ-034 MAC: branch 0 id 0 result 0x0001_0000 overwrite 1, then id 1 result 0x10 overwrite 0 -> acc writes with add_enable 0 then 1.
REQ-035 sample_tick in cycle where id 0 matches, sample_in 0x7FFF -> write (0,0x7FFF), commit of id 0 one cycle later, commits_this_sample 1.
REQ-036 Two branches both holding id 0 -> lowest index commits, id_collision 1 until reset_n low.
REQ-037 next_commit_id 0xFF with ID_WIDTH 8, commit id 0xFF -> next_commit_id 0x00; reset_n low mid-stream -> all outputs 0 immediately.
